// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and port indices for the memory port arbiter
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ACCESS = S_ACCESS,
    ST_DONE   = S_DONE
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] adr0;
  logic [DW-1:0] wd0;
  logic          ack0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wd1;
  logic          ack1;

  logic [DW-1:0] rd;
  logic          busy;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Adr;
  logic [DW-1:0] B_out;
  logic [DW-1:0] Memory_out;

  // master is the environment: both requesters plus the memory itself
  modport master (
    output req0, we0, adr0, wd0, req1, we1, adr1, wd1, Memory_out,
    input  ack0, ack1, rd, busy, MemRead, MemWrite, Adr, B_out
  );

  modport slave (
    input  req0, we0, adr0, wd0, req1, we1, adr1, wd1, Memory_out,
    output ack0, ack1, rd, busy, MemRead, MemWrite, Adr, B_out
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - two-way round-robin tie-break, purely combinational
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_CPU;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else if (req1) begin
      gnt_idx = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory access sequencer with fixed latency and one-cycle ack
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic          we_q;
  logic          win_q;
  logic          last;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rd_q;
  logic          gnt_valid;
  logic          gnt_idx;

  rr_pick2 u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (gnt_valid) state_nx = ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      we_q  <= 1'b0;
      win_q <= PORT_CPU;
      last  <= PORT_DMA;
      adr_q <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            win_q <= gnt_idx;
            last  <= gnt_idx;
            cnt   <= LAT_M1;
            if (gnt_idx == PORT_DMA) begin
              we_q  <= bus.we1;
              adr_q <= bus.adr1;
              wd_q  <= bus.wd1;
            end else begin
              we_q  <= bus.we0;
              adr_q <= bus.adr0;
              wd_q  <= bus.wd0;
            end
          end
        end
        ST_ACCESS: begin
          // memory data is only guaranteed valid in the final access cycle
          if (cnt == 4'd0) begin
            if (!we_q) rd_q <= bus.Memory_out;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.MemRead  = (state == ST_ACCESS) && !we_q;
  assign bus.MemWrite = (state == ST_ACCESS) && we_q;
  assign bus.ack0     = (state == ST_DONE) && (win_q == PORT_CPU);
  assign bus.ack1     = (state == ST_DONE) && (win_q == PORT_DMA);
  assign bus.Adr      = adr_q;
  assign bus.B_out    = wd_q;
  assign bus.rd       = rd_q;

endmodule
